// File: rtl/fpu_sched_if.sv
// Handshake bundle between the FP scheduler and its neighbours: dispatch,
// FPU issue/result, CDB writeback, flush and busy status.
interface fpu_sched_if;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_funct5;
  logic [31:0] disp_op1;
  logic [31:0] disp_op2;
  logic [2:0]  disp_rob_idx;
  logic        fpu_start;
  logic [4:0]  fpu_funct5;
  logic [31:0] fpu_operand1;
  logic [31:0] fpu_operand2;
  logic [2:0]  EXE_rob_idx;
  logic [31:0] fpu_out;
  logic [2:0]  fpu_rob_idx;
  logic        fpu_o_valid;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [2:0]  wb_rob_idx;
  logic        wb_grant;
  logic        busy;

  modport master (
    output flush, disp_valid, disp_funct5, disp_op1, disp_op2, disp_rob_idx,
           fpu_out, fpu_rob_idx, fpu_o_valid, wb_grant,
    input  disp_ready, fpu_start, fpu_funct5, fpu_operand1, fpu_operand2,
           EXE_rob_idx, wb_valid, wb_data, wb_rob_idx, busy
  );

  modport slave (
    input  flush, disp_valid, disp_funct5, disp_op1, disp_op2, disp_rob_idx,
           fpu_out, fpu_rob_idx, fpu_o_valid, wb_grant,
    output disp_ready, fpu_start, fpu_funct5, fpu_operand1, fpu_operand2,
           EXE_rob_idx, wb_valid, wb_data, wb_rob_idx, busy
  );
endinterface

// File: rtl/fpu_sched.sv
// FP add/sub issue queue plus credit-protected result buffer feeding the CDB;
// a ROB flush discards queued, in-flight and buffered work.
module fpu_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RBUF  = 2
) (
  input  logic       clk,
  input  logic       rst,
  fpu_sched_if.slave bus
);
  localparam int unsigned QW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned RW  = $clog2(RBUF);
  localparam int unsigned RCW = $clog2(RBUF + 1);
  localparam logic [CW-1:0] IQ_FULL = CW'(DEPTH);
  localparam logic [RCW:0]  RB_MAX  = (RCW + 1)'(RBUF);
  localparam logic [RW-1:0] RB_LAST = RW'(RBUF - 1);

  typedef struct packed {
    logic [4:0]  funct5;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  rob;
  } iq_ent_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  rob;
  } rb_ent_t;

  iq_ent_t        iq_mem [DEPTH];
  logic [QW-1:0]  iq_head, iq_tail;
  logic [CW-1:0]  iq_count;
  rb_ent_t        rb_mem [RBUF];
  logic [RW-1:0]  rb_head, rb_tail;
  logic [RCW-1:0] rb_count;
  logic           inflight, drop;
  logic           iq_push, iq_pop, rb_push, rb_pop, has_credit;
  iq_ent_t        iq_hd;
  rb_ent_t        rb_hd;

  assign has_credit = ({1'b0, rb_count} + {{RCW{1'b0}}, inflight}) < RB_MAX;

  assign bus.disp_ready = (iq_count < IQ_FULL) & ~bus.flush & ~rst;
  assign bus.fpu_start  = (iq_count != '0) & has_credit & ~bus.flush;
  assign iq_push        = bus.disp_valid & bus.disp_ready;
  assign iq_pop         = bus.fpu_start;

  assign iq_hd            = (iq_count != '0) ? iq_mem[iq_head] : '0;
  assign bus.fpu_funct5   = iq_hd.funct5;
  assign bus.fpu_operand1 = iq_hd.op1;
  assign bus.fpu_operand2 = iq_hd.op2;
  assign bus.EXE_rob_idx  = iq_hd.rob;

  // A result with nothing in flight is a leftover from before reset; ignore it.
  assign rb_push = bus.fpu_o_valid & inflight & ~drop & ~bus.flush;
  assign rb_pop  = bus.wb_valid & bus.wb_grant;

  assign bus.wb_valid   = (rb_count != '0);
  assign rb_hd          = bus.wb_valid ? rb_mem[rb_head] : '0;
  assign bus.wb_data    = rb_hd.data;
  assign bus.wb_rob_idx = rb_hd.rob;

  assign bus.busy = (iq_count != '0) | inflight | (rb_count != '0);

  always_ff @(posedge clk) begin
    if (iq_push)
      iq_mem[iq_tail] <= '{funct5: bus.disp_funct5, op1: bus.disp_op1,
                           op2: bus.disp_op2, rob: bus.disp_rob_idx};
    if (rb_push)
      rb_mem[rb_tail] <= '{data: bus.fpu_out, rob: bus.fpu_rob_idx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iq_head  <= '0;
      iq_tail  <= '0;
      iq_count <= '0;
      rb_head  <= '0;
      rb_tail  <= '0;
      rb_count <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (bus.flush) begin
        iq_head  <= '0;
        iq_tail  <= '0;
        iq_count <= '0;
        rb_head  <= '0;
        rb_tail  <= '0;
        rb_count <= '0;
      end else begin
        if (iq_push) iq_tail <= iq_tail + QW'(1);
        if (iq_pop)  iq_head <= iq_head + QW'(1);
        case ({iq_push, iq_pop})
          2'b10:   iq_count <= iq_count + CW'(1);
          2'b01:   iq_count <= iq_count - CW'(1);
          default: ;
        endcase
        if (rb_push) rb_tail <= (rb_tail == RB_LAST) ? '0 : rb_tail + RW'(1);
        if (rb_pop)  rb_head <= (rb_head == RB_LAST) ? '0 : rb_head + RW'(1);
        case ({rb_push, rb_pop})
          2'b10:   rb_count <= rb_count + RCW'(1);
          2'b01:   rb_count <= rb_count - RCW'(1);
          default: ;
        endcase
      end

      if (bus.fpu_start)        inflight <= 1'b1;
      else if (bus.fpu_o_valid) inflight <= 1'b0;

      // Flushed op still in the FPU: swallow its result when it lands.
      if (bus.fpu_o_valid & inflight)  drop <= 1'b0;
      else if (bus.flush & inflight)   drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fpu_sched.sv
// Randomized bench for fpu_sched: queue-based reference model plus an FPU
// stand-in that returns a real add/sub result one cycle after each issue.
module tb_fpu_sched;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RBUF  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_sched_if bus ();

  fpu_sched #(.DEPTH(DEPTH), .RBUF(RBUF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rob;
  } op_t;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  rob;
  } res_t;

  op_t         iq[$];
  res_t        rbq[$];
  bit          m_inflight, m_drop;
  int unsigned n_vec, n_bad;
  logic        fv_n;
  logic [31:0] fd_n;
  logic [2:0]  fr_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [4:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    return r2f((f == 5'd1) ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  task automatic drive_op(input logic [2:0] rob);
    bus.disp_valid   = 1'b1;
    bus.disp_funct5  = 5'($urandom_range(1, 0));
    bus.disp_op1     = rand_fp();
    bus.disp_op2     = rand_fp();
    bus.disp_rob_idx = rob;
  endtask

  // One clock cycle: present FPU result, optionally pulse reset mid-cycle,
  // compare every output against the model, then advance the model.
  task automatic step(input bit do_rst, output bit acc);
    bit          e_rdy, e_start, e_wbv, fov;
    int unsigned credit;
    op_t         h;
    res_t        r;
    bus.fpu_o_valid = fv_n;
    bus.fpu_out     = fd_n;
    bus.fpu_rob_idx = fr_n;
    #1;
    if (do_rst) begin
      rst = 1'b1;
      #1;
      check_eq("rst_disp_ready", bus.disp_ready, 0);
      check_eq("rst_fpu_start", bus.fpu_start, 0);
      check_eq("rst_wb_valid", bus.wb_valid, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_operand1", bus.fpu_operand1, 0);
      check_eq("rst_wb_data", bus.wb_data, 0);
      iq.delete();
      rbq.delete();
      m_inflight     = 1'b0;
      m_drop         = 1'b0;
      bus.disp_valid = 1'b0;
      bus.flush      = 1'b0;
      rst            = 1'b0;
      #1;
    end
    e_rdy   = (iq.size() < DEPTH) && !bus.flush;
    credit  = RBUF - int'(m_inflight) - rbq.size();
    e_start = (iq.size() != 0) && (credit > 0) && !bus.flush;
    e_wbv   = (rbq.size() != 0);
    h       = (iq.size() != 0) ? iq[0] : '0;
    r       = e_wbv ? rbq[0] : '0;
    check_eq("disp_ready", bus.disp_ready, e_rdy);
    check_eq("fpu_start", bus.fpu_start, e_start);
    check_eq("fpu_funct5", bus.fpu_funct5, h.f);
    check_eq("fpu_operand1", bus.fpu_operand1, h.a);
    check_eq("fpu_operand2", bus.fpu_operand2, h.b);
    check_eq("EXE_rob_idx", bus.EXE_rob_idx, h.rob);
    check_eq("wb_valid", bus.wb_valid, e_wbv);
    check_eq("wb_data", bus.wb_data, r.d);
    check_eq("wb_rob_idx", bus.wb_rob_idx, r.rob);
    check_eq("busy", bus.busy, (iq.size() != 0) || m_inflight || e_wbv);
    acc = bus.disp_valid && e_rdy;
    fv_n = bus.fpu_start;
    fd_n = fpu_calc(bus.fpu_funct5, bus.fpu_operand1, bus.fpu_operand2);
    fr_n = bus.EXE_rob_idx;
    @(posedge clk);
    fov = bus.fpu_o_valid;
    if (bus.flush) begin
      iq.delete();
      rbq.delete();
    end else begin
      if (e_start) void'(iq.pop_front());
      if (acc) iq.push_back('{f: bus.disp_funct5, a: bus.disp_op1, b: bus.disp_op2,
                              rob: bus.disp_rob_idx});
      if (e_wbv && bus.wb_grant) void'(rbq.pop_front());
      if (fov && m_inflight && !m_drop) rbq.push_back('{d: bus.fpu_out, rob: bus.fpu_rob_idx});
    end
    if (fov && m_inflight)              m_drop = 1'b0;
    else if (bus.flush && m_inflight)   m_drop = 1'b1;
    if (e_start)  m_inflight = 1'b1;
    else if (fov) m_inflight = 1'b0;
    @(negedge clk);
  endtask

  always @(posedge clk)
    if (!rst)
      assert (!(dut.rb_push && dut.rb_count == RBUF))
        else $error("push into full result buffer");

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    int unsigned k, guard;
    rst = 1'b1;
    bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.disp_funct5 = '0;
    bus.disp_op1 = '0; bus.disp_op2 = '0; bus.disp_rob_idx = '0;
    bus.wb_grant = 1'b0; bus.fpu_o_valid = 1'b0; bus.fpu_out = '0; bus.fpu_rob_idx = '0;
    fv_n = 1'b0; fd_n = '0; fr_n = '0;
    m_inflight = 1'b0; m_drop = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_disp_ready", bus.disp_ready, 0);
    check_eq("reset_fpu_start", bus.fpu_start, 0);
    check_eq("reset_wb_valid", bus.wb_valid, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_operand1", bus.fpu_operand1, 0);
    rst = 1'b0;
    @(negedge clk);

    // single op: 1.0 + 2.0 -> 3.0, rob 5
    bus.wb_grant = 1'b1;
    bus.disp_valid = 1'b1; bus.disp_funct5 = 5'd0;
    bus.disp_op1 = 32'h3F80_0000; bus.disp_op2 = 32'h4000_0000; bus.disp_rob_idx = 3'd5;
    step(0, acc);
    bus.disp_valid = 1'b0;
    step(0, acc);
    step(0, acc);
    #1;
    check_eq("single_wb_valid", bus.wb_valid, 1);
    check_eq("single_wb_data", bus.wb_data, 32'h4040_0000);
    check_eq("single_wb_rob", bus.wb_rob_idx, 5);
    repeat (3) step(0, acc);

    // back-to-back with grant high
    for (int i = 0; i < 4; i++) begin
      drive_op(3'(i));
      step(0, acc);
    end
    bus.disp_valid = 1'b0;
    repeat (6) step(0, acc);

    // fill and backpressure
    bus.wb_grant = 1'b0;
    k = 0;
    guard = 0;
    while (k < 6 && guard < 40) begin
      drive_op(3'(k));
      step(0, acc);
      if (acc) k++;
      guard++;
    end
    check_eq("bp_accepted", k, 6);
    bus.disp_valid = 1'b0;
    repeat (4) step(0, acc);
    bus.wb_grant = 1'b1;
    repeat (10) step(0, acc);

    // flush while an op is in flight
    drive_op(3'd2); step(0, acc);
    drive_op(3'd3); step(0, acc);
    drive_op(3'd4); bus.flush = 1'b1; step(0, acc);
    bus.flush = 1'b0; bus.disp_valid = 1'b0;
    repeat (3) step(0, acc);
    drive_op(3'd6); step(0, acc);
    bus.disp_valid = 1'b0;
    repeat (4) step(0, acc);

    // async reset with work outstanding
    bus.wb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_op(3'(i));
      step(0, acc);
    end
    bus.disp_valid = 1'b0;
    step(1, acc);
    bus.wb_grant = 1'b1;
    repeat (5) step(0, acc);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99, 0) < 70) drive_op(3'($urandom));
      else bus.disp_valid = 1'b0;
      bus.wb_grant = ($urandom_range(99, 0) < 60);
      bus.flush    = ($urandom_range(39, 0) == 0);
      step($urandom_range(99, 0) == 0, acc);
    end
    bus.disp_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.wb_grant   = 1'b1;
    repeat (8) step(0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
